// File: rtl/glyph_word_encoder.sv
// glyph_word_encoder: recovers the 3-bit UPC code from six seven-segment glyphs of a product word.
// Ports:
//   clk_i          system clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   glyph_i        active-low segment pattern (bit 6 = segment 6)
//   glyph_valid_i  glyph presented this cycle
//   glyph_sof_i    first glyph of a word (HEX5), qualified by glyph_valid_i
//   glyph_ready_o  glyph accepted this cycle when valid
//   upc_o          recovered code, held until the next result
//   upc_valid_o    one-cycle result pulse
//   no_match_o     word not in table, valid with upc_valid_o
//   busy_o         a word is partially received
module glyph_word_encoder #(
  parameter int NUM_DIGITS = 6
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [6:0] glyph_i,
  input  logic       glyph_valid_i,
  input  logic       glyph_sof_i,
  output logic       glyph_ready_o,
  output logic [2:0] upc_o,
  output logic       upc_valid_o,
  output logic       no_match_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, COLLECT, RESULT} state_e;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GS = 7'b0010010;
  localparam logic [6:0] GA = 7'b1001000;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GC = 7'b1000110;
  localparam logic [6:0] GO = 7'b1000000;
  localparam logic [6:0] GH = 7'b0001001;
  localparam logic [6:0] GP = 7'b0001100;
  localparam logic [6:0] GL = 7'b1000111;
  localparam logic [6:0] GY = 7'b0110001;
  localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);
  // Each word is indexed by display number: element 5 is HEX5, the first glyph received.
  localparam logic [5:0][6:0] WORD [6] = '{
    {BL, GS, GA, GF, GE, BL},
    {GC, GO, GF, GF, GE, GE},
    {GC, GH, GE, GS, GS, BL},
    {GA, GP, GP, GL, GE, BL},
    {BL, GC, GO, GP, GY, BL},
    {GC, GH, GE, GE, GS, GE}
  };
  localparam logic [2:0] CODE [6] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
  state_e     state_q;
  logic [2:0] count_q;
  logic [5:0] mask_q;
  logic       ready_q;
  logic [2:0] upc_q;
  logic       upc_valid_q;
  logic       no_match_q;
  logic       busy_q;
  logic [2:0] hex_d;
  logic [5:0] hit_d;
  logic [5:0] mask_d;
  logic [2:0] sel_d;
  logic [2:0] upc_d;
  logic       miss_d;
  logic       accept;
  assign accept = glyph_valid_i && ready_q;
  // A sof glyph (or any glyph outside COLLECT) is always compared as HEX5 and reloads the mask.
  always_comb begin
    hex_d = (state_q == COLLECT && !glyph_sof_i) ? 3'd5 - count_q : 3'd5;
    for (int k = 0; k < 6; k++) hit_d[k] = (WORD[k][hex_d] == glyph_i);
    mask_d = (hex_d == 3'd5) ? hit_d : mask_q & hit_d;
    sel_d = 3'b111;
    for (int k = 0; k < 6; k++) if (mask_d[k]) sel_d = CODE[k];
    miss_d = !$onehot(mask_d);
    upc_d = miss_d ? 3'b111 : sel_d;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mask_q      <= '1;
      ready_q     <= 1'b1;
      upc_q       <= '0;
      upc_valid_q <= 1'b0;
      no_match_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      upc_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && glyph_sof_i) begin
            mask_q  <= mask_d;
            count_q <= 3'd1;
            busy_q  <= 1'b1;
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          if (accept) begin
            mask_q <= mask_d;
            if (glyph_sof_i) begin
              count_q <= 3'd1;
            end else if (count_q == LAST) begin
              state_q     <= RESULT;
              ready_q     <= 1'b0;
              busy_q      <= 1'b0;
              upc_valid_q <= 1'b1;
              upc_q       <= upc_d;
              no_match_q  <= miss_d;
            end else begin
              count_q <= count_q + 3'd1;
            end
          end
        end
        RESULT: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          count_q <= '0;
          mask_q  <= '1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign glyph_ready_o = ready_q;
  assign upc_o         = upc_q;
  assign upc_valid_o   = upc_valid_q;
  assign no_match_o    = no_match_q;
  assign busy_o        = busy_q;
endmodule

// File: tb/tb_glyph_word_encoder.sv
// tb_glyph_word_encoder: directed and randomized check of glyph_word_encoder against a word-table model.
module tb_glyph_word_encoder;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] glyph;
  logic       glyph_valid;
  logic       glyph_sof;
  logic       glyph_ready;
  logic [2:0] upc;
  logic       upc_valid;
  logic       no_match;
  logic       busy;
  int tests = 0;
  int fails = 0;
  logic [4:0] rq[$];
  string tbl[8] = '{"_SAFE_", "COFFEE", "", "CHESS_", "APPLE_", "_COPY_", "CHEESE", ""};
  int codes[6] = '{0, 1, 3, 4, 5, 6};
  string alpha = "_SAFECOHPLY";
  always #5 clk = ~clk;
  glyph_word_encoder dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .glyph_i(glyph),
    .glyph_valid_i(glyph_valid),
    .glyph_sof_i(glyph_sof),
    .glyph_ready_o(glyph_ready),
    .upc_o(upc),
    .upc_valid_o(upc_valid),
    .no_match_o(no_match),
    .busy_o(busy)
  );
  always @(negedge clk) if (reset_n && upc_valid) rq.push_back({glyph_ready, no_match, upc});
  function automatic logic [6:0] lg(input byte c);
    case (c)
      "S": lg = 7'b0010010;
      "A": lg = 7'b1001000;
      "F": lg = 7'b0001110;
      "E": lg = 7'b0000110;
      "C": lg = 7'b1000110;
      "O": lg = 7'b1000000;
      "H": lg = 7'b0001001;
      "P": lg = 7'b0001100;
      "L": lg = 7'b1000111;
      "Y": lg = 7'b0110001;
      default: lg = 7'b1111111;
    endcase
  endfunction
  function automatic logic [41:0] pk(input string s);
    logic [41:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[34:0], lg(s[i])};
    return r;
  endfunction
  // Returns {no_match, upc}: the code whose table word equals the six glyphs, else 1,111.
  function automatic logic [3:0] model(input logic [41:0] w);
    for (int c = 0; c < 8; c++) if (tbl[c].len() == 6 && pk(tbl[c]) == w) return {1'b0, 3'(c)};
    return 4'hf;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [6:0] g, input logic sof);
    int t = 0;
    @(negedge clk);
    glyph = g;
    glyph_sof = sof;
    glyph_valid = 1'b1;
    while (!glyph_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_wait", 32'(glyph_ready), 1);
    @(posedge clk);
    #1 glyph_valid = 1'b0;
    glyph_sof = 1'b0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      glyph_valid = 1'b0;
    end
  endtask
  task automatic run_word(input string tag, input logic [41:0] w, input int gapmax);
    logic [3:0] e;
    logic [4:0] r;
    e = model(w);
    rq.delete();
    for (int i = 0; i < 6; i++) begin
      send(w[41-7*i -: 7], i == 0);
      if (i < 5 && gapmax > 0) idle($urandom_range(0, gapmax));
    end
    chk({tag, "_uv"}, 32'(upc_valid), 1);
    chk({tag, "_rdy0"}, 32'(glyph_ready), 0);
    chk({tag, "_upc"}, 32'(upc), 32'(e[2:0]));
    chk({tag, "_nm"}, 32'(no_match), 32'(e[3]));
    @(negedge clk);
    @(posedge clk);
    #1;
    chk({tag, "_uv_off"}, 32'(upc_valid), 0);
    chk({tag, "_rdy1"}, 32'(glyph_ready), 1);
    chk({tag, "_hold"}, 32'(upc), 32'(e[2:0]));
    chk({tag, "_npulse"}, 32'(rq.size()), 1);
    r = (rq.size() > 0) ? rq[0] : 5'h1f;
    chk({tag, "_pulse"}, 32'(r), {27'd0, 1'b0, e});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [41:0] w;
    logic [4:0] r0;
    logic [4:0] r1;
    reset_n = 1'b0;
    glyph = '1;
    glyph_valid = 1'b0;
    glyph_sof = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(glyph_ready), 1);
    chk("rst_upc", 32'(upc), 0);
    chk("rst_uv", 32'(upc_valid), 0);
    chk("rst_nm", 32'(no_match), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    idle(2);
    run_word("coffee", pk("COFFEE"), 0);
    run_word("safe", pk("_SAFE_"), 0);
    run_word("copy", pk("_COPY_"), 0);
    run_word("cheese", pk("CHEESE"), 0);
    run_word("chess", pk("CHESS_"), 0);
    run_word("chesse", pk("CHESSE"), 0);
    run_word("apple", pk("APPLE_"), 0);
    rq.delete();
    w = pk("COFFEE");
    for (int i = 0; i < 3; i++) send(w[41-7*i -: 7], i == 0);
    chk("partial_busy", 32'(busy), 1);
    run_word("restart", pk("APPLE_"), 0);
    send(lg("S"), 1'b0);
    idle(2);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_pulse", 32'(rq.size()), 1);
    run_word("gapped", pk("_COPY_"), 3);
    rq.delete();
    w = pk("CHEESE");
    for (int i = 0; i < 3; i++) send(w[41-7*i -: 7], i == 0);
    chk("mid_busy", 32'(busy), 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(glyph_ready), 1);
    chk("arst_upc", 32'(upc), 0);
    chk("arst_uv", 32'(upc_valid), 0);
    chk("arst_nm", 32'(no_match), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(10);
    chk("arst_nopulse", 32'(rq.size()), 0);
    chk("arst_busy_after", 32'(busy), 0);
    rq.delete();
    w = pk("COFFEE");
    for (int i = 0; i < 6; i++) send(w[41-7*i -: 7], i == 0);
    @(negedge clk);
    glyph = lg("A");
    glyph_sof = 1'b1;
    glyph_valid = 1'b1;
    chk("hold_rdy0", 32'(glyph_ready), 0);
    @(posedge clk);
    #1;
    chk("hold_not_taken", 32'(busy), 0);
    chk("hold_rdy1", 32'(glyph_ready), 1);
    @(posedge clk);
    #1;
    chk("hold_taken", 32'(busy), 1);
    glyph_valid = 1'b0;
    glyph_sof = 1'b0;
    w = pk("APPLE_");
    for (int i = 1; i < 6; i++) send(w[41-7*i -: 7], 1'b0);
    idle(2);
    chk("hold_npulse", 32'(rq.size()), 2);
    r0 = (rq.size() > 0) ? rq[0] : 5'h1f;
    r1 = (rq.size() > 1) ? rq[1] : 5'h1f;
    chk("hold_first", 32'(r0), 32'h1);
    chk("hold_second", 32'(r1), 32'h4);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: w = pk(tbl[codes[$urandom_range(0, 5)]]);
        2: for (int i = 0; i < 6; i++) w = {w[34:0], lg(alpha[$urandom_range(0, 10)])};
        default: begin
          w = pk(tbl[codes[$urandom_range(0, 5)]]);
          w[41-7*$urandom_range(0, 5) -: 7] = 7'($urandom);
        end
      endcase
      run_word("rand", w, 2);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
